// File: rtl/maxpool2x2_engine.sv
// 2x2 stride-2 signed max-pooling engine: walks a channel-major feature map in a
// sync-read SRAM, one window per 6 cycles, and writes the pooled map linearly.
module maxpool2x2_engine #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned FMAP_W  = 32,
    parameter int unsigned FMAP_H  = 32,
    parameter int unsigned CH      = 16,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned RD_BASE = 0,
    parameter int unsigned WR_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned OUT_W = FMAP_W / 2;
    localparam int unsigned OUT_H = FMAP_H / 2;
    localparam int unsigned PLANE = FMAP_W * FMAP_H;
    localparam int unsigned COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_LAST, S_WR, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] out_idx_q, out_idx_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] merged;
    logic              last_out;
    logic              dy, dx;

    // Next state, window counters, accumulator and the registered outputs for the coming cycle
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        row_d     = row_q;
        col_d     = col_q;
        out_idx_d = out_idx_q;
        acc_d     = acc_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        dy        = 1'b0;
        dx        = 1'b0;

        merged   = ($signed(rd_data) > $signed(acc_q)) ? rd_data : acc_q;
        last_out = (ch_q == CH_W'(CH - 1)) && (row_q == ROW_W'(OUT_H - 1))
                   && (col_q == COL_W'(OUT_W - 1));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RD0;
                    ch_d      = '0;
                    row_d     = '0;
                    col_d     = '0;
                    out_idx_d = '0;
                end
            end
            S_RD0: state_d = S_RD1;
            S_RD1: begin
                acc_d   = rd_data;
                state_d = S_RD2;
            end
            S_RD2: begin
                acc_d   = merged;
                state_d = S_RD3;
            end
            S_RD3: begin
                acc_d   = merged;
                state_d = S_LAST;
            end
            S_LAST: begin
                acc_d     = merged;
                wr_data_d = merged;
                wr_addr_d = ADDR_W'(WR_BASE + 32'(out_idx_q));
                state_d   = S_WR;
            end
            S_WR: begin
                if (last_out) begin
                    state_d = S_DONE;
                end else begin
                    state_d   = S_RD0;
                    out_idx_d = out_idx_q + ADDR_W'(1);
                    if (col_q == COL_W'(OUT_W - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(OUT_H - 1)) begin
                            row_d = '0;
                            ch_d  = ch_q + CH_W'(1);
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Window offset of the read issued in the next cycle
        case (state_d)
            S_RD1:   dx = 1'b1;
            S_RD2:   dy = 1'b1;
            S_RD3: begin
                dy = 1'b1;
                dx = 1'b1;
            end
            default: ;
        endcase

        rd_en_d = (state_d == S_RD0) || (state_d == S_RD1)
                  || (state_d == S_RD2) || (state_d == S_RD3);
        wr_en_d = (state_d == S_WR);
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);

        if (rd_en_d) begin
            rd_addr_d = ADDR_W'(RD_BASE + 32'(ch_d) * PLANE
                        + (2 * 32'(row_d) + 32'(dy)) * FMAP_W
                        + 2 * 32'(col_d) + 32'(dx));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            row_q     <= '0;
            col_q     <= '0;
            out_idx_q <= '0;
            acc_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            row_q     <= row_d;
            col_q     <= col_d;
            out_idx_q <= out_idx_d;
            acc_q     <= acc_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_maxpool2x2_engine.sv
// Bench for maxpool2x2_engine: 4x4x2 map with offset bases, SRAM model and a
// reference pooling model computed directly from the window definition.
module tb_maxpool2x2_engine;

    localparam int DW = 8;
    localparam int FW = 4;
    localparam int FH = 4;
    localparam int NC = 2;
    localparam int AW = 8;
    localparam int RB = 8;
    localparam int WB = 3;
    localparam int N  = NC * (FH / 2) * (FW / 2);
    localparam int BOUND = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:255];
    logic [AW-1:0] rd_log [$];
    int            rd_cyc [$];
    logic [AW-1:0] wa_log [$];
    logic [DW-1:0] wd_log [$];
    int            wr_cyc [$];
    int            done_cyc;
    bit            busy_bad;
    bit            overlap;

    maxpool2x2_engine #(
        .DATA_W(DW), .FMAP_W(FW), .FMAP_H(FH), .CH(NC),
        .ADDR_W(AW), .RD_BASE(RB), .WR_BASE(WB)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // One-cycle-latency input SRAM
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    function automatic logic [DW-1:0] ref_pool(int ch, int r, int c);
        int best;
        best = -1000;
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                int v;
                v = int'($signed(mem[RB + ch*FW*FH + (2*r+dy)*FW + 2*c + dx]));
                if (v > best) best = v;
            end
        return DW'(best);
    endfunction

    function automatic logic [DW-1:0] ref_out(int k);
        return ref_pool(k / ((FH/2)*(FW/2)), (k / (FW/2)) % (FH/2), k % (FW/2));
    endfunction

    function automatic logic [AW-1:0] ref_rd_addr(int j);
        int k, w, ch, r, c;
        k = j / 4; w = j % 4;
        ch = k / ((FH/2)*(FW/2)); r = (k / (FW/2)) % (FH/2); c = k % (FW/2);
        return AW'(RB + ch*FW*FH + (2*r + w/2)*FW + 2*c + w%2);
    endfunction

    task automatic run_capture();
        rd_log.delete(); rd_cyc.delete();
        wa_log.delete(); wd_log.delete(); wr_cyc.delete();
        done_cyc = -1; busy_bad = 0; overlap = 0;
        @(negedge clk) start = 1'b1;
        for (int cyc = 1; cyc <= BOUND; cyc++) begin
            @(posedge clk); #1;
            if (rd_en && wr_en) overlap = 1;
            if (rd_en) begin rd_log.push_back(rd_addr); rd_cyc.push_back(cyc); end
            if (wr_en) begin
                wa_log.push_back(wr_addr); wd_log.push_back(wr_data); wr_cyc.push_back(cyc);
            end
            if (done) begin done_cyc = cyc; break; end
            if (!busy) busy_bad = 1;
        end
    endtask

    task automatic release_start();
        @(negedge clk) start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({rd_en, wr_en, busy, done} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0000", {rd_en, wr_en, busy, done});
        end
        checks++;
        if ({rd_addr, wr_addr, wr_data} !== '0) begin
            errors++; $display("FAIL reset_data: rd_addr=%0d wr_addr=%0d wr_data=%0d want 0", rd_addr, wr_addr, wr_data);
        end
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({rd_en, wr_en, busy, done} !== 4'b0) begin
            errors++; $display("FAIL idle_hold: got %b want 0000", {rd_en, wr_en, busy, done});
        end
    endtask

    task automatic test_random(int iters);
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i < 256; i++) begin
                case ($urandom_range(0, 7))
                    0: mem[i] = 8'h80;
                    1: mem[i] = 8'h7F;
                    default: mem[i] = DW'($urandom);
                endcase
            end
            run_capture();
            checks++;
            if (done_cyc !== 6*N+1) begin
                errors++; $display("FAIL rand_latency it%0d: got %0d want %0d", it, done_cyc, 6*N+1);
            end
            checks++;
            if (busy_bad || overlap) begin
                errors++; $display("FAIL rand_busy_overlap it%0d: busy_bad=%0d overlap=%0d want 0 0", it, busy_bad, overlap);
            end
            checks++;
            if (wa_log.size() != N || rd_log.size() != 4*N) begin
                errors++; $display("FAIL rand_counts it%0d: writes=%0d reads=%0d want %0d %0d", it, wa_log.size(), rd_log.size(), N, 4*N);
            end else begin
                for (int k = 0; k < N; k++) begin
                    checks++;
                    if (wa_log[k] !== AW'(WB + k) || wd_log[k] !== ref_out(k) || wr_cyc[k] !== 6*k+6) begin
                        errors++;
                        $display("FAIL rand_write it%0d k%0d: addr=%0d data=%0d cyc=%0d want %0d %0d %0d",
                                 it, k, wa_log[k], $signed(wd_log[k]), wr_cyc[k], WB + k, $signed(ref_out(k)), 6*k+6);
                    end
                end
                for (int j = 0; j < 4*N; j++) begin
                    checks++;
                    if (rd_log[j] !== ref_rd_addr(j) || rd_cyc[j] !== 6*(j/4) + j%4 + 1) begin
                        errors++;
                        $display("FAIL rand_read it%0d j%0d: addr=%0d cyc=%0d want %0d %0d",
                                 it, j, rd_log[j], rd_cyc[j], ref_rd_addr(j), 6*(j/4) + j%4 + 1);
                    end
                end
            end
            release_start();
        end
    endtask

    task automatic test_sequential();
        logic [DW-1:0] exp_d [8] = '{8'd5, 8'd7, 8'd13, 8'd15, 8'd21, 8'd23, 8'd29, 8'd31};
        for (int i = 0; i < 2*FW*FH; i++) mem[RB + i] = DW'(i);
        run_capture();
        checks++;
        if (done_cyc !== 49) begin
            errors++; $display("FAIL seq_latency: got %0d want 49", done_cyc);
        end
        checks++;
        if (wa_log.size() != 8 || rd_log.size() != 32) begin
            errors++; $display("FAIL seq_counts: writes=%0d reads=%0d want 8 32", wa_log.size(), rd_log.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (wa_log[k] !== AW'(WB + k) || wd_log[k] !== exp_d[k]) begin
                    errors++; $display("FAIL seq_write k%0d: addr=%0d data=%0d want %0d %0d", k, wa_log[k], wd_log[k], WB + k, exp_d[k]);
                end
            end
            checks++;
            if (rd_log[16] !== AW'(RB + 16)) begin
                errors++; $display("FAIL seq_ch1_base: got %0d want %0d", rd_log[16], RB + 16);
            end
        end
    endtask

    task automatic test_done_exit();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({done, busy, rd_en, wr_en} !== 4'b1000) begin
                errors++; $display("FAIL done_hold c%0d: done/busy/rd/wr=%b want 1000", i, {done, busy, rd_en, wr_en});
            end
        end
        release_start();
        checks++;
        if ({done, busy, rd_en, wr_en} !== 4'b0000) begin
            errors++; $display("FAIL done_exit: done/busy/rd/wr=%b want 0000", {done, busy, rd_en, wr_en});
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] prev [$];
        prev = wd_log;
        run_capture();
        checks++;
        if (done_cyc !== 49 || wd_log.size() != prev.size()) begin
            errors++; $display("FAIL b2b_run: done=%0d writes=%0d want 49 %0d", done_cyc, wd_log.size(), prev.size());
        end else begin
            for (int k = 0; k < prev.size(); k++) begin
                checks++;
                if (wd_log[k] !== prev[k] || wd_log[k] !== ref_out(k)) begin
                    errors++; $display("FAIL b2b_data k%0d: got %0d want %0d", k, wd_log[k], ref_out(k));
                end
            end
        end
        release_start();
    endtask

    task automatic test_extremes();
        logic [DW-1:0] w0 [4] = '{8'h80, 8'hFF, 8'hCE, 8'hFE};
        logic [DW-1:0] w1 [4] = '{8'h7F, 8'h80, 8'h7F, 8'h00};
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        for (int w = 0; w < 4; w++) begin
            mem[RB + (w/2)*FW + w%2]     = w0[w];
            mem[RB + (w/2)*FW + 2 + w%2] = w1[w];
            mem[RB + (2 + w/2)*FW + w%2] = 8'h05;
        end
        run_capture();
        checks++;
        if (wd_log.size() != N) begin
            errors++; $display("FAIL ext_count: got %0d want %0d", wd_log.size(), N);
        end else begin
            checks++;
            if (wd_log[0] !== 8'hFF) begin
                errors++; $display("FAIL ext_allneg: got %0d want -1", $signed(wd_log[0]));
            end
            checks++;
            if (wd_log[1] !== 8'h7F) begin
                errors++; $display("FAIL ext_maxpos: got %0d want 127", $signed(wd_log[1]));
            end
            checks++;
            if (wd_log[2] !== 8'h05) begin
                errors++; $display("FAIL ext_ties: got %0d want 5", $signed(wd_log[2]));
            end
        end
        release_start();
    endtask

    task automatic test_reset_midrun();
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        @(negedge clk) start = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (!rd_en || rd_addr !== AW'(RB + FW + 2)) begin
            errors++; $display("FAIL midrun_rd2: rd_en=%0d rd_addr=%0d want 1 %0d", rd_en, rd_addr, RB + FW + 2);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rd_en, wr_en, busy, done} !== 4'b0 || {rd_addr, wr_addr, wr_data} !== '0) begin
            errors++; $display("FAIL midrun_async: ctrl=%b rd_addr=%0d wr_addr=%0d wr_data=%0d want all 0",
                               {rd_en, wr_en, busy, done}, rd_addr, wr_addr, wr_data);
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({rd_en, wr_en, busy, done} !== 4'b0) begin
            errors++; $display("FAIL midrun_idle: ctrl=%b want 0000", {rd_en, wr_en, busy, done});
        end
        run_capture();
        checks++;
        if (done_cyc !== 6*N+1 || wd_log.size() != N) begin
            errors++; $display("FAIL midrun_rerun: done=%0d writes=%0d want %0d %0d", done_cyc, wd_log.size(), 6*N+1, N);
        end else begin
            for (int k = 0; k < N; k++) begin
                checks++;
                if (wa_log[k] !== AW'(WB + k) || wd_log[k] !== ref_out(k)) begin
                    errors++; $display("FAIL midrun_map k%0d: addr=%0d data=%0d want %0d %0d", k, wa_log[k], wd_log[k], WB + k, ref_out(k));
                end
            end
        end
        release_start();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_done_exit();
        test_back_to_back();
        test_extremes();
        test_random(4);
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
